// File: rtl/gpio_input_conditioner_pkg.sv
// Shared constants for the GPIO input conditioner: register offsets and window geometry.
package gpio_pkg;
    localparam int GPIO_W      = 16;
    localparam int WINDOW_BITS = 8;

    localparam logic [1:0] OFF_PEND = 2'b00;
    localparam logic [1:0] OFF_RAW  = 2'b01;
    localparam logic [1:0] OFF_RISE = 2'b10;
    localparam logic [1:0] OFF_FALL = 2'b11;
endpackage

// File: rtl/gpio_input_conditioner_if.sv
// Bus control signals of the shared memory-mapped bus (data stays a top-level inout).
interface gpio_input_conditioner_if;
    logic [31:0] address;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;

    modport master (output address, output mem_read, output mem_write, output size);
    modport slave  (input  address, input  mem_read, input  mem_write, input  size);
endinterface

// File: rtl/AddressDetect.sv
// Chip-select decode: address matches BASE_ADDR under MASK.
module AddressDetect #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] MASK      = 32'hFFFF_FF00
) (
    input  logic [31:0] i_address,
    output logic        o_match
);
    assign o_match = ((i_address & MASK) == (BASE_ADDR & MASK));
endmodule

// File: rtl/gpio_input_conditioner_debounce_bit.sv
// One pin: 2-flop synchroniser, stability counter, debounced level and edge pulses.
module gpio_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_sync,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);
    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_prev   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1   <= i_pin;
            r_s2   <= r_s1;
            r_prev <= r_stable;
            // Any sample agreeing with the current level restarts qualification.
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_sync   = r_s2;
    assign o_stable = r_stable;
    assign o_rise   = r_stable & ~r_prev;
    assign o_fall   = ~r_stable & r_prev;
endmodule

// File: rtl/gpio_input_conditioner.sv
// GPIO input conditioner: per-pin debounce, edge-latched interrupt pending register,
// and a small register window on the shared 64-bit data bus.
module gpio_input_conditioner
    import gpio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter int          CNT_W           = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    gpio_input_conditioner_if.slave  bus,
    inout  wire  [63:0]              data,
    input  logic [GPIO_W-1:0]        pins_in,
    output logic [GPIO_W-1:0]        clean_out,
    output logic                     irq
);
    logic              w_cs;
    logic              w_rd;
    logic              w_wr;
    logic [1:0]        w_off;
    logic [GPIO_W-1:0] w_sync;
    logic [GPIO_W-1:0] w_stable;
    logic [GPIO_W-1:0] w_rise;
    logic [GPIO_W-1:0] w_fall;
    logic [GPIO_W-1:0] w_wdata;
    logic [GPIO_W-1:0] w_w1c;
    logic [GPIO_W-1:0] w_pend_next;
    logic [GPIO_W-1:0] w_rd_data;
    logic              w_unused;

    logic [GPIO_W-1:0] r_pend;
    logic [GPIO_W-1:0] r_rise_en;
    logic [GPIO_W-1:0] r_fall_en;

    AddressDetect #(
        .BASE_ADDR (BASE_ADDR),
        .MASK      (32'hFFFF_FFFF << WINDOW_BITS)
    ) u_addr_detect (
        .i_address (bus.address),
        .o_match   (w_cs)
    );

    for (genvar gi = 0; gi < GPIO_W; gi++) begin : g_bit
        gpio_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk      (clock),
            .rst_n    (reset),
            .i_pin    (pins_in[gi]),
            .o_sync   (w_sync[gi]),
            .o_stable (w_stable[gi]),
            .o_rise   (w_rise[gi]),
            .o_fall   (w_fall[gi])
        );
    end

    // Simultaneous read and write strobes are treated as an idle bus cycle.
    assign w_rd    = w_cs & bus.mem_read & ~bus.mem_write;
    assign w_wr    = w_cs & bus.mem_write & ~bus.mem_read;
    assign w_off   = bus.address[4:3];
    assign w_wdata = data[GPIO_W-1:0];
    assign w_w1c   = (w_wr && w_off == OFF_PEND) ? w_wdata : '0;

    // New edges are ORed in after the clear so a set always wins.
    assign w_pend_next = (r_pend & ~w_w1c) | (w_rise & r_rise_en) | (w_fall & r_fall_en);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pend    <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else begin
            r_pend <= w_pend_next;
            if (w_wr && w_off == OFF_RISE) r_rise_en <= w_wdata;
            if (w_wr && w_off == OFF_FALL) r_fall_en <= w_wdata;
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (w_off)
            OFF_PEND: w_rd_data = r_pend;
            OFF_RAW:  w_rd_data = w_sync;
            OFF_RISE: w_rd_data = r_rise_en;
            OFF_FALL: w_rd_data = r_fall_en;
            default:  w_rd_data = '0;
        endcase
    end

    assign data      = w_rd ? {48'b0, w_rd_data} : 64'bz;
    assign clean_out = w_stable;
    assign irq       = |r_pend;

    // Access size and sub-register address bits carry no meaning for 16-bit registers.
    assign w_unused = &{1'b0, bus.size, bus.address[7:5], bus.address[2:0], data[63:GPIO_W]};
endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed self-checking bench for gpio_input_conditioner with DEBOUNCE_CYCLES=4.
module tb_gpio_input_conditioner;
    import gpio_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] A_PEND = BASE + 32'h00;
    localparam logic [31:0] A_RAW  = BASE + 32'h08;
    localparam logic [31:0] A_RISE = BASE + 32'h10;
    localparam logic [31:0] A_FALL = BASE + 32'h18;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pins_in = 16'h0000;
    logic [15:0] clean_out;
    logic        irq;
    logic        tb_drive = 1'b0;
    logic [63:0] tb_wdata = 64'h0;
    wire  [63:0] data;
    logic [63:0] rd;
    int          n_total = 0;
    int          n_fail  = 0;

    gpio_input_conditioner_if bus_if();

    assign data = tb_drive ? tb_wdata : 64'bz;

    gpio_input_conditioner #(
        .BASE_ADDR       (BASE),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (8)
    ) dut (
        .clock     (clock),
        .reset     (rst_n),
        .bus       (bus_if.slave),
        .data      (data),
        .pins_in   (pins_in),
        .clean_out (clean_out),
        .irq       (irq)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [15:0] val);
        bus_if.address   = addr;
        bus_if.size      = 2'b11;
        bus_if.mem_write = 1'b1;
        tb_wdata         = {48'b0, val};
        tb_drive         = 1'b1;
        tick();
        bus_if.mem_write = 1'b0;
        tb_drive         = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [63:0] val);
        bus_if.address  = addr;
        bus_if.size     = 2'b01;
        bus_if.mem_read = 1'b1;
        #1;
        val = data;
        bus_if.mem_read = 1'b0;
        #1;
    endtask

    initial begin
        bus_if.address   = 32'h0;
        bus_if.mem_read  = 1'b0;
        bus_if.mem_write = 1'b0;
        bus_if.size      = 2'b00;

        // Reset state
        repeat (3) tick();
        chk("rst_clean", {48'b0, clean_out}, 64'h0);
        rst_n = 1'b1;
        tick();
        bus_read(A_PEND, rd); chk("rst_pend", rd, 64'h0);
        bus_read(A_RISE, rd); chk("rst_rise_en", rd, 64'h0);
        bus_read(A_FALL, rd); chk("rst_fall_en", rd, 64'h0);
        chk("rst_irq", {63'b0, irq}, 64'h0);
        tb_wdata = 64'hA5A5_5A5A_0F0F_F0F0;
        tb_drive = 1'b1;
        #1; chk("bus_idle_free", data, 64'hA5A5_5A5A_0F0F_F0F0);
        tb_drive = 1'b0;

        // Out-of-window and dual-strobe writes must not land
        bus_write(32'h0000_2010, 16'hFFFF);
        bus_read(A_RISE, rd); chk("cs_miss_wr", rd, 64'h0);
        bus_if.address = A_FALL; bus_if.mem_read = 1'b1; bus_if.mem_write = 1'b1;
        tb_wdata = 64'h0000_0000_0000_FFFF; tb_drive = 1'b1;
        tick();
        bus_if.mem_read = 1'b0; bus_if.mem_write = 1'b0; tb_drive = 1'b0;
        bus_read(A_FALL, rd); chk("rw_both_idle", rd, 64'h0);

        // Rising edge on bit 0
        bus_write(A_RISE, 16'h0001);
        pins_in[0] = 1'b1;
        repeat (5) tick();
        chk("b0_clean_e5", {48'b0, clean_out}, 64'h0);
        tick();
        chk("b0_clean_e6", {48'b0, clean_out}, 64'h1);
        chk("b0_irq_e6", {63'b0, irq}, 64'h0);
        tick();
        chk("b0_irq_e7", {63'b0, irq}, 64'h1);
        bus_read(A_PEND, rd); chk("b0_pend", rd, 64'h0000000000000001);

        // Short glitch on bit 3
        pins_in[3] = 1'b1;
        tick(); tick();
        bus_read(A_RAW, rd); chk("b3_raw_pulse", rd, 64'h0009);
        tick();
        pins_in[3] = 1'b0;
        repeat (10) tick();
        chk("b3_clean", {48'b0, clean_out}, 64'h0001);
        bus_read(A_PEND, rd); chk("b3_pend", rd, 64'h0001);
        bus_write(A_RAW, 16'hFFFF);
        bus_read(A_RAW, rd); chk("raw_ro", rd, 64'h0001);

        // W1C of bit 0
        bus_write(A_PEND, 16'h0001);
        bus_read(A_PEND, rd); chk("w1c_b0", rd, 64'h0);
        chk("w1c_b0_irq", {63'b0, irq}, 64'h0);

        // Falling edge on bit 15
        bus_write(A_FALL, 16'h8000);
        pins_in[15] = 1'b1;
        repeat (8) tick();
        chk("b15_qual", {48'b0, clean_out}, 64'h8001);
        bus_read(A_PEND, rd); chk("b15_rise_masked", rd, 64'h0);
        pins_in[15] = 1'b0;
        repeat (7) tick();
        bus_read(A_PEND, rd); chk("b15_fall_pend", rd, 64'h8000);
        bus_write(A_PEND, 16'h0000);
        bus_read(A_PEND, rd); chk("w0_no_effect", rd, 64'h8000);
        bus_write(A_PEND, 16'h8000);
        bus_read(A_PEND, rd); chk("w1c_b15", rd, 64'h0);
        chk("w1c_b15_irq", {63'b0, irq}, 64'h0);

        // Set wins over a simultaneous clear on bit 2
        bus_write(A_RISE, 16'h0005);
        pins_in[2] = 1'b1;
        repeat (6) tick();
        bus_write(A_PEND, 16'h0004);
        bus_read(A_PEND, rd); chk("set_wins_b2", rd, 64'h0004);
        bus_write(A_RISE, 16'h0000);
        bus_read(A_PEND, rd); chk("en_clr_keeps", rd, 64'h0004);

        // Reset mid-debounce on bit 5
        bus_write(A_RISE, 16'h0020);
        pins_in[5] = 1'b1;
        repeat (4) tick();
        chk("b5_pre_rst", {48'b0, clean_out}, 64'h0005);
        rst_n = 1'b0;
        #1;
        chk("rst_async_clean", {48'b0, clean_out}, 64'h0);
        chk("rst_async_irq", {63'b0, irq}, 64'h0);
        bus_read(A_PEND, rd); chk("rst_async_pend", rd, 64'h0);
        bus_read(A_RISE, rd); chk("rst_async_rise", rd, 64'h0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("requal_e5", {48'b0, clean_out}, 64'h0);
        tick();
        chk("requal_e6", {48'b0, clean_out}, 64'h0025);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end
endmodule

// File: doc/gpio_input_conditioner.md
Name: gpio_input_conditioner

Overview:
- Memory-mapped input-conditioning stage between the 16 external GPIO pads and the IN path of the 16-bit GPIO port.
- Conditions each pin in three steps: 2-flop synchroniser, per-bit debounce counter, edge detector.
- Drives the debounced pins to the GPIO port IN register.
- Latches rising/falling edges into an interrupt-pending register readable over the shared 64-bit bi-directional data bus.

Parameters:
- BASE_ADDR, 32'h00000000, base of this block's 256-byte window.
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required before clean_out changes (legal range 1..255).
- CNT_W, 8, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clock  in  1  single system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- data  inout  64  shared data bus; driven only during a selected read, else high-Z.
- address  in  32  bus address; chip select via AddressDetect, mask 32'hFFFFFFFF<<8.
- mem_read  in  1  read strobe.
- mem_write  in  1  write strobe.
- size  in  2  access size; ignored, all accesses treated as 16-bit.
- pins_in  in  16  raw asynchronous pad inputs.
- clean_out  out  16  debounced pin levels, to GPIO port IN.
- irq  out  1  OR of all pending bits.

Behaviour:

Reset (asserted low, asynchronous): all of the following clear to 0.
- sync stages, stable (clean_out), prev_stable, counters
- PEND, RISE_EN, FALL_EN
- irq=0, data=Z.

Synchroniser:
- s1<=pins_in; s2<=s1.

Debounce, per bit:
- If s2==stable: cnt<=0.
- Else if cnt==DEBOUNCE_CYCLES-1: stable<=s2, cnt<=0.
- Else: cnt<=cnt+1.
- Any glitch shorter than DEBOUNCE_CYCLES samples returns cnt to 0 and leaves clean_out unchanged.
- Latency: pad change at edge 0 becomes visible on clean_out after edge 2+DEBOUNCE_CYCLES.

Edge detection:
- prev_stable<=stable.
- rise=stable&~prev_stable; fall=~stable&prev_stable.
- PEND sets on the edge after clean_out changes (edge 3+DEBOUNCE_CYCLES).

Register map (address[4:3], valid when chip_select):
- 00 PEND: read returns {48'b0,PEND}. Write of 1 clears the bit (W1C); write of 0 has no effect.
- 01 RAW: read-only; returns {48'b0,s2}. Writes are ignored.
- 10 RISE_EN: read/write, data[15:0].
- 11 FALL_EN: read/write, data[15:0].

PEND update:
- PEND_next = (PEND & ~w1c) | (rise&RISE_EN) | (fall&FALL_EN).
- Set wins over a simultaneous clear.

Bus transfers:
- Write: takes effect at the clock edge where chip_select & mem_write & ~mem_read.
- Read: data driven combinationally while chip_select & mem_read & ~mem_write; otherwise 64'bz.
- mem_read and mem_write both high: no read, no write.

Outputs and masks:
- irq = |PEND; combinational from registers, no glitch path from the bus.
- Enable bits gate setting of PEND only. Clearing an enable leaves existing PEND bits set.
- Reset mid-debounce: counters and clean_out return to 0 immediately. Pins held high re-qualify after 2+DEBOUNCE_CYCLES edges following deassertion.

Decomposition:
- Package gpio_pkg holds the register offset constants (OFF_PEND=2'b00, OFF_RAW=2'b01, OFF_RISE=2'b10, OFF_FALL=2'b11) and the window size constant 8.
- Sub-module gpio_debounce_bit: sync + counter + stable + prev, parameterised DEBOUNCE_CYCLES/CNT_W, outputs stable/rise/fall. Instantiated 16 times via generate.
- AddressDetect reused for chip select.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset then read PEND/RISE_EN/FALL_EN -> all 64'h0, clean_out=16'h0000, irq=0; with no read active, data=Z.
- RISE_EN=16'h0001; pins_in[0] 0->1 held -> clean_out[0]=1 after edge 6; PEND=16'h0001 and irq=1 after edge 7; read PEND returns 64'h0000000000000001.
- pins_in[3] pulse high for 3 cycles -> clean_out[3] stays 0, PEND unchanged, RAW shows the pulse.
- FALL_EN=16'h8000; pins_in[15] held 1 (qualifies), then 1->0 -> PEND[15]=1; write PEND=16'h8000 -> PEND=0, irq=0.
- W1C of bit 2 on the same edge a rising edge on bit 2 sets it (RISE_EN[2]=1) -> PEND[2] remains 1.
- Assert reset (low) while bit 5's counter is at 2 -> clean_out, PEND and RISE_EN read 0 immediately; after release with pin high, clean_out[5]=1 after 6 edges.
